// File: rtl/rc4_decrypt_fsm.sv
// rc4_decrypt_fsm
//   RC4 PRGA stage. It runs after the KSA shuffle has finished and shares the
//   S memory with it through the S-memory mux. For each byte k it produces one
//   keystream byte, XORs it with encrypted ROM byte k, and writes the
//   plaintext to decrypted RAM address k.
//
// Build option:
//   DECRYPT_VALID_CHECK_EN - when defined, the FSM stops early if a plaintext
//   byte is not lowercase ASCII or space, and raises key_invalid. When it is
//   not defined, key_invalid is tied low and every byte is processed.
//
// Ports:
//   CLOCK_50          system clock; all state changes on the rising edge
//   reset_n           asynchronous active-low reset
//   start             level; sampled only in IDLE
//   s_data_in         S-memory read data (synchronous-read memory)
//   s_address_out     S-memory address
//   s_data_out        S-memory write data
//   s_write_enable    S-memory write strobe
//   rom_address       encrypted ROM address
//   rom_data_in       encrypted ROM read data (synchronous-read memory)
//   ram_address       decrypted RAM address
//   ram_data_out      plaintext byte
//   ram_write_enable  RAM write strobe
//   ready             high in IDLE only
//   done              high in DONE only
//   key_invalid       early-abort flag (build option)
//
// state        | meaning
// -------------+-----------------------------------------------
// IDLE         | waiting for start
// SETUP_SI     | register S address = i
// WAIT_SI      | S memory read in flight
// READ_SI      | capture si
// CALC_J       | j = j + si
// SETUP_SJ     | register S address = j
// WAIT_SJ      | S memory read in flight
// READ_SJ      | capture sj
// SETUP_WR_SI  | register address i, data sj
// WR_SI        | write S[i]
// SETUP_WR_SJ  | register address j, data si
// WR_SJ        | write S[j]
// SETUP_F      | register S address = si + sj, ROM address = k
// WAIT_F       | S and ROM reads in flight
// READ_F       | capture keystream byte f and cipher byte c
// SETUP_RAM    | register RAM address = k, data = f ^ c
// WRITE_RAM    | write RAM[k]
// NEXT_K       | advance to next byte, or finish
// DONE         | hold done until start drops

module rc4_decrypt_fsm #(
    parameter int MESSAGE_LENGTH = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            s_data_in,
    output logic [7:0]            s_address_out,
    output logic [7:0]            s_data_out,
    output logic                  s_write_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [7:0]            rom_data_in,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_data_out,
    output logic                  ram_write_enable,
    output logic                  ready,
    output logic                  done,
    output logic                  key_invalid
);

    typedef enum logic [4:0] {
        ST_IDLE, ST_SETUP_SI, ST_WAIT_SI, ST_READ_SI, ST_CALC_J,
        ST_SETUP_SJ, ST_WAIT_SJ, ST_READ_SJ, ST_SETUP_WR_SI, ST_WR_SI,
        ST_SETUP_WR_SJ, ST_WR_SJ, ST_SETUP_F, ST_WAIT_F, ST_READ_F,
        ST_SETUP_RAM, ST_WRITE_RAM, ST_NEXT_K, ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(MESSAGE_LENGTH - 1);

    state_t                state, state_next;
    logic [7:0]            i, j, si, sj, f, c;
    logic [ADDR_WIDTH-1:0] k;
    logic [7:0]            plain;
    logic                  abort;

    assign plain = f ^ c;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        s_write_enable   = 1'b0;
        ram_write_enable = 1'b0;
        ready            = 1'b0;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = ST_SETUP_SI;
            end
            ST_SETUP_SI:    state_next = ST_WAIT_SI;
            ST_WAIT_SI:     state_next = ST_READ_SI;
            ST_READ_SI:     state_next = ST_CALC_J;
            ST_CALC_J:      state_next = ST_SETUP_SJ;
            ST_SETUP_SJ:    state_next = ST_WAIT_SJ;
            ST_WAIT_SJ:     state_next = ST_READ_SJ;
            ST_READ_SJ:     state_next = ST_SETUP_WR_SI;
            ST_SETUP_WR_SI: state_next = ST_WR_SI;
            ST_WR_SI: begin
                s_write_enable = 1'b1;
                state_next     = ST_SETUP_WR_SJ;
            end
            ST_SETUP_WR_SJ: state_next = ST_WR_SJ;
            ST_WR_SJ: begin
                s_write_enable = 1'b1;
                state_next     = ST_SETUP_F;
            end
            ST_SETUP_F:     state_next = ST_WAIT_F;
            ST_WAIT_F:      state_next = ST_READ_F;
            ST_READ_F:      state_next = ST_SETUP_RAM;
            ST_SETUP_RAM:   state_next = ST_WRITE_RAM;
            ST_WRITE_RAM: begin
                ram_write_enable = 1'b1;
                state_next       = ST_NEXT_K;
            end
            ST_NEXT_K: begin
                if (abort || k == K_LAST) state_next = ST_DONE;
                else                      state_next = ST_SETUP_SI;
            end
            ST_DONE: begin
                done = 1'b1;
                // No auto-restart: start must drop before another run.
                if (!start) state_next = ST_IDLE;
            end
            default:        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            i             <= 8'd0;
            j             <= 8'd0;
            k             <= '0;
            si            <= 8'd0;
            sj            <= 8'd0;
            f             <= 8'd0;
            c             <= 8'd0;
            s_address_out <= 8'd0;
            s_data_out    <= 8'd0;
            rom_address   <= '0;
            ram_address   <= '0;
            ram_data_out  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // PRGA pre-increments i, so the first byte uses i = 1.
                    if (start) begin
                        i <= 8'd1;
                        j <= 8'd0;
                        k <= '0;
                    end
                end
                ST_SETUP_SI:  s_address_out <= i;
                ST_READ_SI:   si <= s_data_in;
                ST_CALC_J:    j <= j + si;
                ST_SETUP_SJ:  s_address_out <= j;
                ST_READ_SJ:   sj <= s_data_in;
                ST_SETUP_WR_SI: begin
                    s_address_out <= i;
                    s_data_out    <= sj;
                end
                ST_SETUP_WR_SJ: begin
                    s_address_out <= j;
                    s_data_out    <= si;
                end
                ST_SETUP_F: begin
                    // Swapped values sum to the same index as before the swap.
                    s_address_out <= si + sj;
                    rom_address   <= k;
                end
                ST_READ_F: begin
                    f <= s_data_in;
                    c <= rom_data_in;
                end
                ST_SETUP_RAM: begin
                    ram_address  <= k;
                    ram_data_out <= plain;
                end
                ST_NEXT_K: begin
                    if (state_next == ST_SETUP_SI) begin
                        k <= k + ADDR_WIDTH'(1);
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DECRYPT_VALID_CHECK_EN
    logic byte_bad;
    logic key_invalid_q;
    logic is_text;

    assign is_text     = (plain >= 8'h61 && plain <= 8'h7A) || (plain == 8'h20);
    assign abort       = byte_bad;
    assign key_invalid = key_invalid_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            byte_bad      <= 1'b0;
            key_invalid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:      if (start) key_invalid_q <= 1'b0;
                ST_SETUP_RAM: byte_bad <= !is_text;
                // The bad byte has already been written in WRITE_RAM.
                ST_NEXT_K:    if (byte_bad) key_invalid_q <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign abort       = 1'b0;
    assign key_invalid = 1'b0;
`endif

endmodule

// File: doc/rc4_decrypt_fsm.md
Name: rc4_decrypt_fsm

Overview:
- RC4 PRGA stage, directly downstream of the KSA shuffle FSM.
- Starts when the shuffle reports finished. Shares S memory with it through the S-memory mux.
- Per byte: generates one keystream byte, XORs it with encrypted ROM byte k, writes the plaintext to decrypted RAM address k.
- Reports done, plus an optional early-abort invalid-key flag used by the key-search controller.

Parameters:
- MESSAGE_LENGTH, 32: number of ciphertext/plaintext bytes processed.
- ADDR_WIDTH, 5: ROM/RAM address width; MESSAGE_LENGTH <= 2**ADDR_WIDTH.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  level; sampled only in IDLE.
- s_data_in  in  8  S-memory read data.
- s_address_out  out  8  S-memory address.
- s_data_out  out  8  S-memory write data.
- s_write_enable  out  1  S-memory write strobe.
- rom_address  out  ADDR_WIDTH  encrypted ROM address.
- rom_data_in  in  8  encrypted ROM read data.
- ram_address  out  ADDR_WIDTH  decrypted RAM address.
- ram_data_out  out  8  plaintext byte.
- ram_write_enable  out  1  RAM write strobe.
- ready  out  1  high in IDLE only.
- done  out  1  high in DONE only.
- key_invalid  out  1  early-abort flag (see Optional Feature).

Behaviour:
- Memories: S and ROM are synchronous-read. The address is driven from a register in a SETUP state; data is sampled two cycles later in a READ state, with a WAIT state between. Writes commit on the edge where the write enable is high; address and data are registered one state earlier.
- Reset (async, reset_n=0):
  - state=IDLE; i=0, j=0, k=0.
  - All address/data outputs 0; all write enables 0; done=0; key_invalid=0; ready=1 after release.
- State sequence per byte, one cycle each, 17 cycles per byte:
  - SETUP_SI: s_address_out<=i.
  - WAIT_SI.
  - READ_SI: si<=s_data_in.
  - CALC_J: j<=j+si, mod 256.
  - SETUP_SJ: s_address_out<=j.
  - WAIT_SJ.
  - READ_SJ: sj<=s_data_in.
  - SETUP_WR_SI: addr=i, data=sj.
  - WR_SI: s_write_enable=1.
  - SETUP_WR_SJ: addr=j, data=si.
  - WR_SJ: s_write_enable=1.
  - SETUP_F: s_address_out<=si+sj mod 256; rom_address<=k.
  - WAIT_F.
  - READ_F: f<=s_data_in; c<=rom_data_in.
  - SETUP_RAM: ram_address<=k; ram_data_out<=f^c.
  - WRITE_RAM: ram_write_enable=1.
  - NEXT_K:
    - if k==MESSAGE_LENGTH-1: go to DONE;
    - else k<=k+1, i<=i+1 mod 256, go to SETUP_SI.
- IDLE: on start=1, load i=1, j=0, k=0 and go to SETUP_SI.
- Latency: done rises exactly 17*MESSAGE_LENGTH cycles after the edge that samples start.
- DONE: holds done=1 and all write enables 0. Returns to IDLE when start=0. start held high keeps it in DONE, so there is no auto-restart.
- i and j wrap 255->0. The i==j swap writes the same value twice; this is legal.
- start is ignored outside IDLE.
- reset_n asserted mid-byte aborts immediately; a partially written RAM byte is not retried.
- Write enables are never high in the same cycle as each other.

Optional Feature:
- Macro: DECRYPT_VALID_CHECK_EN.
- Defined:
  - In SETUP_RAM, the plaintext byte is valid only if it is 0x61..0x7A or 0x20.
  - On an invalid byte, the byte is still written in WRITE_RAM.
  - NEXT_K then sets key_invalid<=1 and goes to DONE regardless of k.
  - key_invalid clears on reset_n or on leaving IDLE.
- Undefined: key_invalid is constant 0 and all MESSAGE_LENGTH bytes are always processed.

Test Plan:
- S preloaded with identity (s[x]=x), ROM all 0x00, MESSAGE_LENGTH=3, pulse start:
  - RAM = {0x02,0x05,0x07};
  - final S[2]=3, S[3]=5, S[5]=2;
  - done high exactly 51 cycles after start sampled.
- Identity S, ROM = {0x63,0x64,0x62}: RAM = {0x61,0x61,0x65}, key_invalid=0 in both builds.
- Identity S, ROM byte0 = 0x00, with DECRYPT_VALID_CHECK_EN:
  - RAM[0]=0x02 written;
  - key_invalid=1;
  - done asserted 17 cycles after start;
  - RAM[1] untouched.
  - Without the macro, all bytes are processed and key_invalid=0.
- Assert reset_n in WR_SI of byte 1:
  - same cycle: all write enables 0, done=0;
  - after release, ready=1 and no memory writes until the next start.
- start held high through DONE: done stays 1 and no further writes occur. Drop start: ready=1 next cycle.
- Raise start while busy, mid-byte 0: no change to sequence or done timing versus the first test.
